// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU word, RAM status and arbiter state types
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic [1:0] {IDLE, DGRANT, IGRANT, TRAP} arb_state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester-side and RAM-side signals of the memory arbiter
interface mem_arbiter_if;
  import cpu_types_pkg::*;
  logic iREN, dREN, dWEN, iwait, dwait, ramREN, ramWEN, err;
  word_t iaddr, iload, daddr, dstore, dload, ramaddr, ramstore, ramload;
  ramstate_t ramstate;
  modport slave (
    input iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: data-priority arbiter onto the unified RAM with stall timeout and sticky error
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input logic clk,
  input logic nRST,
  mem_arbiter_if.slave mif
);
  arb_state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic dreq, dgrant, igrant, access, own_req;
  assign dreq = mif.dREN | mif.dWEN;
  assign dgrant = state_q == DGRANT;
  assign igrant = state_q == IGRANT;
  assign access = mif.ramstate == ACCESS;
  assign own_req = dgrant ? dreq : mif.iREN;
  assign mif.ramaddr = dgrant ? mif.daddr : igrant ? mif.iaddr : '0;
  assign mif.ramstore = dgrant ? mif.dstore : '0;
  assign mif.ramWEN = dgrant & mif.dWEN;
  assign mif.ramREN = dgrant ? mif.dREN & ~mif.dWEN : igrant;
  assign mif.iwait = mif.iREN & ~(igrant & access);
  assign mif.dwait = dreq & ~(dgrant & access);
  assign mif.iload = mif.ramload;
  assign mif.dload = mif.ramload;
  assign mif.err = err_q;
  // next state: grant selection, completion/withdrawal, stall counting and timeout trap
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_q == IDLE) begin
      state_d = dreq ? DGRANT : mif.iREN ? IGRANT : IDLE;
    end else if (dgrant || igrant) begin
      if (!own_req || access) begin
        state_d = IDLE;
        cnt_d = '0;
      end else begin
        cnt_d = &cnt_q ? cnt_q : cnt_q + 16'd1;
        err_d = err_q | (mif.ramstate == ERROR);
        if (cnt_q == 16'(TIMEOUT - 1)) begin
          state_d = TRAP;
          err_d = 1'b1;
        end
      end
    end
  end
  // state registers; reset abandons any access at once
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the datapath's instruction-fetch and data-access requests onto the single-ported unified RAM. Sits directly downstream of the request unit: consumes its registered `imemREN`/`dmemREN`/`dmemWEN` strobes and returns the wait signals from which `ihit`/`dhit` are derived. Also supervises the RAM: it times out stalled accesses and latches a sticky error flag.

## Interface
- `TIMEOUT`, default 16: consecutive non-ACCESS cycles one grant may last before the error trap.
- `clk`  in  1  clock
- `nRST`  in  1  reset, asynchronous, active-low
- `iREN`  in  1  instruction read request
- `iaddr`  in  32  instruction address (`word_t`)
- `iwait`  out  1  instruction request not yet satisfied
- `iload`  out  32  instruction word
- `dREN`  in  1  data read request
- `dWEN`  in  1  data write request
- `daddr`  in  32  data address
- `dstore`  in  32  data write value
- `dwait`  out  1  data request not yet satisfied
- `dload`  out  32  data read value
- `ramREN`  out  1  RAM read enable
- `ramWEN`  out  1  RAM write enable
- `ramaddr`  out  32  RAM address
- `ramstore`  out  32  RAM write data
- `ramload`  in  32  RAM read data
- `ramstate`  in  2  `ramstate_t`: FREE, BUSY, ACCESS, ERROR
- `err`  out  1  sticky fault flag

## Operation
- FSM states: IDLE, DGRANT, IGRANT, TRAP. Registered: state, 16-bit stall counter `cnt`, `err`.
- IDLE: if `dREN|dWEN`, go to DGRANT; else if `iREN`, go to IGRANT; else stay. Data has strict priority.
- DGRANT drives the RAM outputs from the data port:
  - `ramaddr=daddr`, `ramstore=dstore`.
  - `ramWEN=dWEN`, `ramREN=dREN&!dWEN`. When both are high, the access is a write.
- IGRANT drives `ramaddr=iaddr`, `ramREN=1`, `ramWEN=0`, `ramstore=0`.
- IDLE and TRAP drive all RAM outputs to 0.
- Completion: in a grant state with `ramstate==ACCESS`, the owning wait drops that cycle. Next state is IDLE and `cnt` clears.
- `iload` and `dload` equal `ramload` combinationally at all times. They are valid only in the cycle the owning wait is low.
- `iwait` = `iREN & !(IGRANT & ACCESS)`.
- `dwait` = `(dREN|dWEN) & !(DGRANT & ACCESS)`.
- Requesters hold the request, address and data stable until their wait drops.
- Withdrawal: if the owner's request falls while in a grant state, go to IDLE next cycle with no RAM side effect beyond the current cycle, and clear `cnt`.
- `ramstate==ERROR` in a grant state:
  - set `err`, stay in the grant state (retry), and increment `cnt`.
  - The wait signals stay high.
- Timeout: in a grant state without ACCESS, `cnt` increments. At `cnt==TIMEOUT-1` without ACCESS, go to TRAP and set `err`.
- TRAP is absorbing until reset: RAM outputs are 0 and both waits follow their requests.
- `err` never clears except by reset.

## Timing
- Async reset to IDLE, `cnt=0`, `err=0`.
  - Reset values: `ramREN=ramWEN=0`, `ramaddr=ramstore=0`. `iwait`/`dwait` equal their request inputs.
- Reset mid-access abandons the access immediately. The RAM enables drop asynchronously.
- Latency: request first high in cycle N (IDLE), grant in N+1. The earliest completion (wait low) is N+1.
- Back-to-back: after a completion in cycle M, IDLE in M+1 and the next grant in M+2. The arbiter spends one IDLE cycle between accesses.
- Simultaneous `iREN` and `dREN` in IDLE: data is served first and the instruction is granted after the next IDLE cycle. `iwait` stays high throughout.
- A request arriving during another port's grant is not preempted.
- `cnt` width is 16 bits; `TIMEOUT` must be at least 2 and at most 65535. `cnt` saturates and never wraps.

## Structure
- `word_t` and `ramstate_t` come from `cpu_types_pkg`.
- Add `arb_state_t` (IDLE, DGRANT, IGRANT, TRAP) to `cpu_types_pkg`.
- Single module with no sub-modules; next-state/output logic and registers are kept separate.

## Test plan
- Reset, then `iREN=1`, `iaddr=0x4`, RAM ACCESS after 3 BUSY cycles, `ramload=0x2000_0001`. Required: `iwait` high for 4 cycles then low for one cycle with `iload=0x2000_0001`, then IDLE.
- `iREN`, `dREN` and `dWEN` all high in the same cycle, `daddr=0x80`, `dstore=0xDEAD_BEEF`. Required: write granted first with `ramWEN=1`, `ramREN=0`, `ramaddr=0x80`; instruction granted only after `dwait` drops plus one IDLE cycle.
- RAM never returns ACCESS, `TIMEOUT=16`. Required: TRAP entered 16 cycles after the grant, `err=1`, RAM enables 0, `iwait` stuck high.
- One ERROR cycle, then ACCESS. Required: `err=1`, the access completes normally, FSM returns to IDLE, and `err` is still 1.
- `dREN` dropped two cycles into DGRANT. Required: IDLE next cycle, `cnt=0`, and a following `iREN` is granted normally.
- Assert `nRST` low during IGRANT. Required: all RAM enables drop asynchronously, state is IDLE, `err=0`.
